z80_bus_capture_seq: RTL and testbench
======================================

# z80_bus_capture_seq

Sequencer for the shared 8-bit snoop bus `Lin` between the Z80 host and the ZX Spectrum VGA core. On every host memory or I/O cycle, it enables the three external tri-state latches one at a time: address low, address high, then data. It samples each byte, then decides what to write. Video-window memory writes go to the dual-port video RAM's write port; ULA port writes update the border colour. It replaces the ad-hoc counter-driven strobe logic in the top level and owns all bus-buffer enables and RAM write timing.

## Interface
- `SETTLE`, 3: cycles an enable is held before the sample cycle (bus settling, covers the input register).
- `WE_LEN`, 5: `ram_we` pulse length in cycles.
- `WIN_LO`, 16'h4000: lowest captured address.
- `WIN_HI`, 16'h5AFF: highest captured address.

Ports:
- `clk_master`  in  1  100 MHz clock
- `rst_pos`  in  1  reset; asynchronous, active-high
- `mreq_n`, `iorq_n`, `wr_n`  in  1 each  raw Z80 strobes, active-low, asynchronous
- `lin`  in  8  shared snoop bus
- `en_al_n`, `en_ah_n`, `en_d_n`  out  1 each  latch/buffer enables, active-low
- `ram_we`  out  1  video RAM write enable
- `ram_addr`  out  13  host address minus `WIN_LO`
- `ram_din`  out  8  write data
- `border`  out  3  border colour
- `border_we`  out  1  one-cycle strobe on border update
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- Synchronisation:
  - `mreq_n`, `iorq_n` and `wr_n` each pass through a 2-FF synchroniser (`*_s`).
  - `lin` is registered once (`lin_r`); all samples use `lin_r`.
- States: IDLE, AL, AH, D, DECIDE, WRITE, WAIT_END.
- IDLE:
  - Exits when `mreq_s`=0 or `iorq_s`=0.
  - Latches the cycle type; memory has priority if both are low.
  - Goes to AL.
- AL / AH / D slots, each `SETTLE`+2 cycles:
  - The slot's enable is low for cycles 0..`SETTLE`.
  - `lin_r` is sampled into `addr_lo` / `addr_hi` / `data` at cycle `SETTLE`.
  - Cycle `SETTLE`+1 is a dead cycle with all enables high (break-before-make).
  - At most one enable is low at any time.
- DECIDE:
  - Waits for `wr_s`=0; the Z80 asserts WR after MREQ.
  - If the strobe deasserts first (read, refresh or INTA cycle), go to IDLE with no action.
  - With `wr_s`=0, a memory cycle and `WIN_LO`≤{`addr_hi`,`addr_lo`}≤`WIN_HI` (unsigned, inclusive):
    - Load `ram_addr` = (addr − `WIN_LO`)[12:0] and `ram_din` = `data`.
    - Go to WRITE.
  - With `wr_s`=0, an I/O cycle and `addr_lo[0]`=0:
    - `border` <= `data[2:0]`, `border_we` high for 1 cycle.
    - Go to WAIT_END.
  - Any other case goes to WAIT_END.
- WRITE:
  - `ram_we` is high for exactly `WE_LEN` cycles.
  - `ram_addr` and `ram_din` are held stable through the pulse and one cycle after.
  - Then go to WAIT_END.
  - The write always completes, even if the host strobe ends mid-pulse.
- WAIT_END: returns to IDLE when the latched strobe is synced high.
- Abort: if the latched strobe goes high during AL, AH or D:
  - All enables go high on the next cycle.
  - No write, no border update; go to IDLE.
- Reset values:
  - `en_*_n`=1, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `border`=3'b000, `border_we`=0, `busy`=0.
  - State IDLE; internal byte registers 0.
  - Reset mid-operation: outputs are forced to their reset values asynchronously, within the same cycle.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Detect latency: the strobe falling at the pin produces `en_al_n` low 3 clock edges later (2 sync + 1 FSM).
- With default parameters:
  - Each slot is 5 cycles; the capture phase is 15 cycles (150 ns), well inside one 3.5 MHz T-state pair.
  - `ram_we` rises the cycle after DECIDE sees `wr_s`=0.
- A back-to-back host cycle must see strobes high for at least 2 synchronised cycles. Otherwise it merges with the previous cycle and is ignored.
- `busy` mirrors state ≠ IDLE with no extra delay.

## Test plan
- Memory write to 16'h4000, data 8'hAA:
  - Enables go low in order AL, AH, D, each for 4 cycles, with 1 dead cycle between them.
  - `ram_we` is high for 5 cycles with `ram_addr`=13'h0000 and `ram_din`=8'hAA.
- Boundaries:
  - Writes to 16'h5AFF produce `ram_addr`=13'h1AFF with a write.
  - Writes to 16'h3FFF and 16'h5B00 produce no `ram_we`, and the FSM returns to IDLE.
- I/O write to port 16'h00FE, data 8'h05: `border`=3'b101 and `border_we` is high for 1 cycle. Port 16'h00FF produces no change.
- Memory read (`wr_n` held high) at 16'h4100: all three bytes are captured, no `ram_we`, and `busy` drops 3 cycles after `mreq_n` rises.
- Abort: `mreq_n` rises during the AH slot. All enables are high within 3 cycles of the pin edge, with no write.
- Reset: `rst_pos` pulsed during the 3rd `ram_we` cycle forces `ram_we`=0 and `border`=0 immediately. The next write cycle then completes normally.
- Assertion over all tests: never more than one of `en_al_n`, `en_ah_n`, `en_d_n` low at once.

Source files
------------

// File: rtl/z80_bus_capture_seq.sv
// Z80 snoop-bus capture sequencer: steps the AL/AH/D latch enables over the shared
// bus, then issues a video-RAM write or a border update for qualifying host cycles.
module z80_bus_capture_seq #(
   parameter int unsigned SETTLE = 3,
   parameter int unsigned WE_LEN = 5,
   parameter logic [15:0] WIN_LO = 16'h4000,
   parameter logic [15:0] WIN_HI = 16'h5AFF
) (
   input  logic        clk_master,
   input  logic        rst_pos,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        wr_n,
   input  logic [7:0]  lin,
   output logic        en_al_n,
   output logic        en_ah_n,
   output logic        en_d_n,
   output logic        ram_we,
   output logic [12:0] ram_addr,
   output logic [7:0]  ram_din,
   output logic [2:0]  border,
   output logic        border_we,
   output logic        busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_AL       = 3'd1;
   localparam logic [2:0] S_AH       = 3'd2;
   localparam logic [2:0] S_D        = 3'd3;
   localparam logic [2:0] S_DECIDE   = 3'd4;
   localparam logic [2:0] S_WRITE    = 3'd5;
   localparam logic [2:0] S_WAIT_END = 3'd6;

   localparam int unsigned   CW        = 8;
   localparam logic [CW-1:0] SAMPLE_C  = CW'(SETTLE);
   localparam logic [CW-1:0] DEAD_C    = CW'(SETTLE + 1);
   localparam logic [CW-1:0] WE_LAST_C = CW'(WE_LEN - 1);

   logic          mreq_m_q, mreq_s_q, iorq_m_q, iorq_s_q, wr_m_q, wr_s_q;
   logic [7:0]    lin_r_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_mem_q, is_mem_d;
   logic [7:0]    addr_lo_q, addr_lo_d, addr_hi_q, addr_hi_d, data_q, data_d;
   logic          en_al_n_q, en_al_n_d, en_ah_n_q, en_ah_n_d, en_d_n_q, en_d_n_d;
   logic          ram_we_q, ram_we_d;
   logic [12:0]   ram_addr_q, ram_addr_d;
   logic [7:0]    ram_din_q, ram_din_d;
   logic [2:0]    border_q, border_d;
   logic          border_we_q, border_we_d;

   logic [15:0]   cap_addr;
   logic          in_win;
   logic          strb_s;

   assign cap_addr = {addr_hi_q, addr_lo_q};
   assign in_win   = (cap_addr >= WIN_LO) && (cap_addr <= WIN_HI);
   assign strb_s   = is_mem_q ? mreq_s_q : iorq_s_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_mem_d    = is_mem_q;
      addr_lo_d   = addr_lo_q;
      addr_hi_d   = addr_hi_q;
      data_d      = data_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      border_d    = border_q;
      border_we_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!mreq_s_q || !iorq_s_q) begin
               is_mem_d = !mreq_s_q;
               state_d  = S_AL;
            end
         end
         S_AL, S_AH, S_D: begin
            if (strb_s) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               if (cnt_q == SAMPLE_C) begin
                  case (state_q)
                     S_AL:    addr_lo_d = lin_r_q;
                     S_AH:    addr_hi_d = lin_r_q;
                     default: data_d    = lin_r_q;
                  endcase
               end
               if (cnt_q == DEAD_C) begin
                  cnt_d   = '0;
                  state_d = (state_q == S_AL) ? S_AH : (state_q == S_AH) ? S_D : S_DECIDE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DECIDE: begin
            // A seen write wins over a strobe release observed in the same cycle
            if (!wr_s_q) begin
               if (is_mem_q && in_win) begin
                  ram_addr_d = cap_addr[12:0] - WIN_LO[12:0];
                  ram_din_d  = data_q;
                  ram_we_d   = 1'b1;
                  cnt_d      = '0;
                  state_d    = S_WRITE;
               end else begin
                  if (!is_mem_q && !addr_lo_q[0]) begin
                     border_d    = data_q[2:0];
                     border_we_d = 1'b1;
                  end
                  state_d = S_WAIT_END;
               end
            end else if (strb_s) begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (cnt_q == WE_LAST_C) begin
               ram_we_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_WAIT_END;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_END: begin
            if (strb_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Enables decoded from the next state so they land registered with the slot
      en_al_n_d = !((state_d == S_AL) && (cnt_d <= SAMPLE_C));
      en_ah_n_d = !((state_d == S_AH) && (cnt_d <= SAMPLE_C));
      en_d_n_d  = !((state_d == S_D)  && (cnt_d <= SAMPLE_C));
   end

   always_ff @(posedge clk_master or posedge rst_pos) begin
      if (rst_pos) begin
         // Synchronisers reset to the inactive (high) strobe level
         mreq_m_q    <= 1'b1;
         mreq_s_q    <= 1'b1;
         iorq_m_q    <= 1'b1;
         iorq_s_q    <= 1'b1;
         wr_m_q      <= 1'b1;
         wr_s_q      <= 1'b1;
         lin_r_q     <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_mem_q    <= 1'b0;
         addr_lo_q   <= '0;
         addr_hi_q   <= '0;
         data_q      <= '0;
         en_al_n_q   <= 1'b1;
         en_ah_n_q   <= 1'b1;
         en_d_n_q    <= 1'b1;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         border_q    <= '0;
         border_we_q <= 1'b0;
      end else begin
         mreq_m_q    <= mreq_n;
         mreq_s_q    <= mreq_m_q;
         iorq_m_q    <= iorq_n;
         iorq_s_q    <= iorq_m_q;
         wr_m_q      <= wr_n;
         wr_s_q      <= wr_m_q;
         lin_r_q     <= lin;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_mem_q    <= is_mem_d;
         addr_lo_q   <= addr_lo_d;
         addr_hi_q   <= addr_hi_d;
         data_q      <= data_d;
         en_al_n_q   <= en_al_n_d;
         en_ah_n_q   <= en_ah_n_d;
         en_d_n_q    <= en_d_n_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         border_q    <= border_d;
         border_we_q <= border_we_d;
      end
   end

   assign en_al_n   = en_al_n_q;
   assign en_ah_n   = en_ah_n_q;
   assign en_d_n    = en_d_n_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign border    = border_q;
   assign border_we = border_we_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_z80_bus_capture_seq.sv
// Scoreboard bench for z80_bus_capture_seq: directed host cycles push expected
// RAM writes / border updates; a negedge monitor pops and compares them.
module tb_z80_bus_capture_seq;

   localparam int unsigned WE_LEN = 5;

   logic        clk_master = 1'b0;
   logic        rst_pos;
   logic        mreq_n, iorq_n, wr_n;
   logic [7:0]  lin;
   logic        en_al_n, en_ah_n, en_d_n;
   logic        ram_we;
   logic [12:0] ram_addr;
   logic [7:0]  ram_din;
   logic [2:0]  border;
   logic        border_we;
   logic        busy;

   logic [7:0]  cur_al = 8'h00, cur_ah = 8'h00, cur_d = 8'h00;

   z80_bus_capture_seq #(
      .SETTLE(3),
      .WE_LEN(WE_LEN),
      .WIN_LO(16'h4000),
      .WIN_HI(16'h5AFF)
   ) dut (
      .clk_master(clk_master),
      .rst_pos(rst_pos),
      .mreq_n(mreq_n),
      .iorq_n(iorq_n),
      .wr_n(wr_n),
      .lin(lin),
      .en_al_n(en_al_n),
      .en_ah_n(en_ah_n),
      .en_d_n(en_d_n),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_din(ram_din),
      .border(border),
      .border_we(border_we),
      .busy(busy)
   );

   always #5 clk_master = ~clk_master;

   // External latches onto the shared bus; idle bus floats to FF
   assign lin = !en_al_n ? cur_al : !en_ah_n ? cur_ah : !en_d_n ? cur_d : 8'hFF;

   typedef struct {
      bit          is_border;
      logic [12:0] addr;
      logic [7:0]  data;
      int unsigned len;
   } exp_t;

   exp_t exp_q[$];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_write(input logic [12:0] a, input logic [7:0] d, input int unsigned len);
      exp_t e;
      e.is_border = 1'b0;
      e.addr      = a;
      e.data      = d;
      e.len       = len;
      exp_q.push_back(e);
   endfunction

   function automatic void push_border(input logic [2:0] b);
      exp_t e;
      e.is_border = 1'b1;
      e.addr      = '0;
      e.data      = {5'b0, b};
      e.len       = 1;
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   bit          in_we = 1'b0;
   int unsigned we_len = 0, bw_len = 0, stable_bad = 0, onehot_viol = 0;
   logic [12:0] snap_addr;
   logic [7:0]  snap_din;
   exp_t        cur_exp;

   always @(negedge clk_master) begin
      if ($countones({~en_al_n, ~en_ah_n, ~en_d_n}) > 1) onehot_viol++;
      if (ram_we) begin
         if (!in_we) begin
            in_we     = 1'b1;
            we_len    = 1;
            snap_addr = ram_addr;
            snap_din  = ram_din;
            if (exp_q.size() == 0 || exp_q[0].is_border) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_ram_we: write to %h data %h, expected none", ram_addr, ram_din);
               cur_exp.is_border = 1'b0;
               cur_exp.addr      = ram_addr;
               cur_exp.data      = ram_din;
               cur_exp.len       = WE_LEN;
            end else begin
               cur_exp = exp_q.pop_front();
               check("sb_ram_addr", 32'(ram_addr), 32'(cur_exp.addr));
               check("sb_ram_din", 32'(ram_din), 32'(cur_exp.data));
            end
         end else begin
            we_len++;
            if (ram_addr !== snap_addr || ram_din !== snap_din) stable_bad++;
         end
      end else if (in_we) begin
         in_we = 1'b0;
         check("sb_we_len", we_len, cur_exp.len);
         check("sb_we_stable", stable_bad, 0);
         stable_bad = 0;
         if (cur_exp.len == WE_LEN)
            check("sb_hold_after_we", 32'({ram_addr, ram_din}), 32'({snap_addr, snap_din}));
      end
      if (border_we) begin
         bw_len++;
         if (bw_len == 1) begin
            if (exp_q.size() == 0 || !exp_q[0].is_border) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_border_we: border %b, expected no update", border);
            end else begin
               cur_exp = exp_q.pop_front();
               check("sb_border", 32'(border), 32'(cur_exp.data[2:0]));
            end
         end
      end else if (bw_len != 0) begin
         check("sb_border_we_len", bw_len, 1);
         bw_len = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while (busy && n < 20) begin
         @(posedge clk_master);
         #1;
         n++;
      end
      check({name, "_idle"}, 32'(busy), 0);
   endtask

   task automatic host_cycle(input bit mem, input logic [15:0] a, input logic [7:0] d,
                             input bit wr, input string name);
      cur_al = a[7:0];
      cur_ah = a[15:8];
      cur_d  = d;
      @(posedge clk_master);
      #1;
      if (mem) mreq_n = 1'b0;
      else     iorq_n = 1'b0;
      repeat (2) @(posedge clk_master);
      #1;
      if (wr) wr_n = 1'b0;
      repeat (30) @(posedge clk_master);
      #1;
      mreq_n = 1'b1;
      iorq_n = 1'b1;
      wr_n   = 1'b1;
      wait_idle(name);
      repeat (3) @(posedge clk_master);
   endtask

   // Enable pattern {al,ah,d} at the k-th negedge after the strobe is driven low
   function automatic logic [2:0] exp_en(input int k);
      if (k >= 3  && k <= 6)  return 3'b011;
      if (k >= 8  && k <= 11) return 3'b101;
      if (k >= 13 && k <= 16) return 3'b110;
      return 3'b111;
   endfunction

   task automatic trace_enables();
      logic [2:0]  got;
      int unsigned bad = 0;
      int          first = -1;
      @(posedge clk_master);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_master);
         got = {en_al_n, en_ah_n, en_d_n};
         if (got !== exp_en(i)) begin
            if (first < 0) first = i;
            bad++;
         end
      end
      check("enable_sequence_bad_cycles", bad, 0);
      if (first >= 0) $display("  first enable deviation at cycle %0d", first);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int unsigned n;
      int unsigned d_low;
      rst_pos = 1'b1;
      mreq_n  = 1'b1;
      iorq_n  = 1'b1;
      wr_n    = 1'b1;
      repeat (3) @(posedge clk_master);
      #1;
      check("reset_enables", 32'({en_al_n, en_ah_n, en_d_n}), 32'h7);
      check("reset_ram", 32'({ram_we, ram_addr, ram_din}), 0);
      check("reset_border", 32'({border, border_we}), 0);
      check("reset_busy", 32'(busy), 0);
      @(negedge clk_master);
      rst_pos = 1'b0;
      repeat (3) @(posedge clk_master);

      // Memory write 4000/AA with enable-sequence trace
      push_write(13'h0000, 8'hAA, WE_LEN);
      fork
         host_cycle(1'b1, 16'h4000, 8'hAA, 1'b1, "wr_4000");
         trace_enables();
      join

      // Window boundaries
      push_write(13'h1AFF, 8'h77, WE_LEN);
      host_cycle(1'b1, 16'h5AFF, 8'h77, 1'b1, "wr_5aff");
      host_cycle(1'b1, 16'h3FFF, 8'h11, 1'b1, "wr_3fff");
      host_cycle(1'b1, 16'h5B00, 8'h22, 1'b1, "wr_5b00");

      // ULA port writes
      push_border(3'b101);
      host_cycle(1'b0, 16'h00FE, 8'h05, 1'b1, "io_fe");
      check("border_after_fe", 32'(border), 32'h5);
      host_cycle(1'b0, 16'h00FF, 8'h02, 1'b1, "io_ff");
      check("border_after_ff", 32'(border), 32'h5);

      // Memory read: busy drops on the third edge after mreq_n rises
      cur_al = 8'h00; cur_ah = 8'h41; cur_d = 8'h99;
      @(posedge clk_master);
      #1 mreq_n = 1'b0;
      repeat (25) @(posedge clk_master);
      #1 mreq_n = 1'b1;
      repeat (3) @(negedge clk_master);
      check("read_busy_before_drop", 32'(busy), 1);
      @(negedge clk_master);
      check("read_busy_dropped", 32'(busy), 0);
      wait_idle("rd_4100");
      repeat (3) @(posedge clk_master);

      // Abort during the AH slot
      cur_al = 8'h10; cur_ah = 8'h40; cur_d = 8'h5A;
      @(posedge clk_master);
      #1 mreq_n = 1'b0;
      repeat (2) @(posedge clk_master);
      #1 wr_n = 1'b0;
      repeat (6) @(posedge clk_master);
      #1;
      check("abort_in_ah_slot", 32'(en_ah_n), 0);
      mreq_n = 1'b1;
      wr_n   = 1'b1;
      repeat (3) @(negedge clk_master);
      check("abort_not_early", 32'(en_ah_n), 0);
      @(negedge clk_master);
      check("abort_enables_high", 32'({en_al_n, en_ah_n, en_d_n}), 32'h7);
      check("abort_busy", 32'(busy), 0);
      d_low = 0;
      repeat (12) begin
         @(negedge clk_master);
         if (!en_d_n || busy) d_low++;
      end
      check("abort_stays_idle", d_low, 0);

      // Reset during the third ram_we cycle
      push_write(13'h0123, 8'h9E, 3);
      cur_al = 8'h23; cur_ah = 8'h41; cur_d = 8'h9E;
      @(posedge clk_master);
      #1 mreq_n = 1'b0;
      repeat (2) @(posedge clk_master);
      #1 wr_n = 1'b0;
      n = 0;
      do begin
         @(negedge clk_master);
         n++;
      end while (!ram_we && n < 60);
      check("rst_test_we_seen", 32'(ram_we), 1);
      repeat (2) @(negedge clk_master);
      #2;
      rst_pos = 1'b1;
      mreq_n  = 1'b1;
      wr_n    = 1'b1;
      #1;
      check("rst_async_ram_we", 32'(ram_we), 0);
      check("rst_async_border", 32'(border), 0);
      check("rst_async_ram_addr", 32'(ram_addr), 0);
      check("rst_async_busy_en", 32'({busy, en_al_n, en_ah_n, en_d_n}), 32'h7);
      #1 rst_pos = 1'b0;
      repeat (3) @(posedge clk_master);

      push_write(13'h0ABC, 8'hC3, WE_LEN);
      host_cycle(1'b1, 16'h4ABC, 8'hC3, 1'b1, "wr_after_rst");

      repeat (10) @(posedge clk_master);
      check("sb_drained", exp_q.size(), 0);
      check("onehot_enables", onehot_viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
